// File: rtl/imm_gen_buf.sv
// imm_gen_buf: immediate extender feeding a registered 2-entry skid buffer with valid/ready and flush
module imm_gen_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_err
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_buf: XLEN must be 32 or 64");
  end
  // in_instr[n] carries instruction bit n+7
  logic signed [31:0] v;
  logic [5:0]         shamt;
  logic [XLEN-1:0]    imm_d;
  logic               err_d;
  logic               mv, kv;
  logic [XLEN-1:0]    k_imm;
  logic               k_err;
  logic               acc, pop;
  // Sign-extending formats built at 32 bits, widened by a signed cast
  always_comb begin
    v = '0;
    case (in_immsrc)
      3'd0: v = {{20{in_instr[24]}}, in_instr[24:13]};
      3'd1: v = {{20{in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
      3'd2: v = {{20{in_instr[24]}}, in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
      3'd3: v = {{12{in_instr[24]}}, in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0};
      3'd4: v = {in_instr[24:5], 12'b0};
      default: v = '0;
    endcase
  end
  assign shamt = (XLEN == 64) ? in_instr[18:13] : {1'b0, in_instr[17:13]};
  assign imm_d = in_immsrc == 3'd5 ? XLEN'(in_instr[12:8]) :
                 in_immsrc == 3'd6 ? XLEN'(shamt) :
                 XLEN'(v);
  assign err_d = &in_immsrc;
  assign in_ready  = ~kv;
  assign out_valid = mv;
  assign acc = in_valid & in_ready;
  assign pop = mv & out_ready;
  // M drives the outputs, K catches the entry that arrives while M is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv      <= 1'b0;
      kv      <= 1'b0;
      out_imm <= '0;
      out_err <= 1'b0;
      k_imm   <= '0;
      k_err   <= 1'b0;
    end else if (flush) begin
      mv <= 1'b0;
      kv <= 1'b0;
    end else if (pop & kv) begin
      out_imm <= k_imm;
      out_err <= k_err;
      kv      <= 1'b0;
    end else if (acc & (~mv | pop)) begin
      out_imm <= imm_d;
      out_err <= err_d;
      mv      <= 1'b1;
    end else if (acc) begin
      k_imm <= imm_d;
      k_err <= err_d;
      kv    <= 1'b1;
    end else if (pop) begin
      mv <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_gen_buf.sv
// tb_imm_gen_buf: scoreboard bench driving XLEN=32 and XLEN=64 instances with identical stimulus
module tb_imm_gen_buf;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [24:0] in_instr = '0;
  logic [2:0]  in_immsrc = '0;
  logic rdy32, rdy64, v32, v64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  typedef struct packed {logic [31:0] e32; logic [63:0] e64; logic err;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  imm_gen_buf #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy32), .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_err(err32));
  imm_gen_buf #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy64), .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_err(err64));

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // Monitor: every handshake on the output pops and checks the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (v32 && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got imm %h with empty scoreboard", imm32);
      end else begin
        e = q.pop_front();
        chk("imm32", 64'(imm32), 64'(e.e32));
        chk("err32", 64'(err32), 64'(e.err));
        chk("imm64", imm64, e.e64);
        chk("err64", 64'(err64), 64'(e.err));
        chk("valid64", 64'(v64), 64'(1'b1));
      end
    end
  end

  task automatic push(logic [31:0] ins, logic [2:0] sel, logic [31:0] e32, logic [63:0] e64, logic err);
    int n = 0;
    in_valid = 1; in_instr = ins[31:7]; in_immsrc = sel;
    while (!(rdy32 && rdy64) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", rdy32);
    end else q.push_back('{e32, e64, err});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d entries outstanding, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(rdy32), 64'(1'b1));
    chk("rst_out_valid", 64'(v32), 64'(1'b0));
    chk("rst_imm32", 64'(imm32), 64'(0));
    chk("rst_imm64", imm64, 64'(0));
    chk("rst_err", 64'(err32), 64'(1'b0));
    rst = 0;
    // I / B / S / small positive I at full rate
    out_ready = 1;
    push(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
    chk("latency1", 64'(v32), 64'(1'b1));
    push(32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
    push(32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
    push(32'h00500093, 3'd0, 32'h5, 64'h5, 0);
    // J / U
    push(32'h001000EF, 3'd3, 32'h800, 64'h800, 0);
    push(32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 0);
    // ZIMM / SHAMT / illegal
    push(32'h3401F073, 3'd5, 32'h3, 64'h3, 0);
    push(32'h03F09093, 3'd6, 32'h1F, 64'h3F, 0);
    push(32'hFFFFFFFF, 3'd7, 32'h0, 64'h0, 1);
    push(32'h12345678, 3'd7, 32'h0, 64'h0, 1);
    drain();
    // Backpressure: A, B buffered, C held upstream
    out_ready = 0;
    push(32'h00500093, 3'd0, 32'h5, 64'h5, 0);
    push(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
    chk("bp_in_ready", 64'(rdy32), 64'(1'b0));
    in_valid = 1; in_instr = 25'(32'h00700093 >> 7); in_immsrc = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ready", 64'(rdy32), 64'(1'b0));
      chk("bp_hold_imm", 64'(imm32), 64'(32'h5));
      chk("bp_hold_valid", 64'(v32), 64'(1'b1));
    end
    in_valid = 0;
    out_ready = 1;
    push(32'h00700093, 3'd0, 32'h7, 64'h7, 0);
    drain();
    // Flush with both entries full and a new entry offered in the same cycle
    out_ready = 0;
    push(32'h00100093, 3'd0, 32'h1, 64'h1, 0);
    push(32'h00200093, 3'd0, 32'h2, 64'h2, 0);
    chk("fl_full", 64'(rdy32), 64'(1'b0));
    flush = 1; in_valid = 1; in_instr = 25'(32'h00300093 >> 7); in_immsrc = 3'd0;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    q.delete();
    chk("fl_out_valid", 64'(v32), 64'(1'b0));
    chk("fl_out_valid64", 64'(v64), 64'(1'b0));
    chk("fl_in_ready", 64'(rdy32), 64'(1'b1));
    chk("fl_imm_hold", 64'(imm32), 64'(32'h1));
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    chk("fl_no_stale", 64'(v32), 64'(1'b0));
    push(32'h00400093, 3'd0, 32'h4, 64'h4, 0);
    chk("fl_latency", 64'(v32), 64'(1'b1));
    drain();
    // Asynchronous reset with two entries buffered
    out_ready = 0;
    push(32'h00500093, 3'd0, 32'h5, 64'h5, 0);
    push(32'h00600093, 3'd7, 32'h0, 64'h0, 1);
    #2 rst = 1;
    #1;
    chk("ar_out_valid", 64'(v32), 64'(1'b0));
    chk("ar_in_ready", 64'(rdy32), 64'(1'b1));
    chk("ar_imm32", 64'(imm32), 64'(0));
    chk("ar_imm64", imm64, 64'(0));
    chk("ar_err", 64'(err64), 64'(1'b0));
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    push(32'h00900093, 3'd0, 32'h9, 64'h9, 0);
    chk("ar_latency", 64'(v32), 64'(1'b1));
    drain();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
